// File: rtl/slurm16_memory_responder.sv
// Memory responder: arbitrates one backing store between the CPU bus and a DMA master.
// Optional build macro SLURM16_MEM_STATS_EN adds the cpu_stall_count statistic.

module slurm16_memory_responder #(
    parameter int WAIT_STATES = 0,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [14:0] memory_address,
    input  logic [15:0] memory_out,
    input  logic        memory_wr,
    input  logic [1:0]  memory_wr_mask,
    output logic [15:0] memory_in,
    output logic        memory_success,
    input  logic [14:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_req,
    input  logic        dma_wr,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    output logic [1:0]  mem_wr_mask,
    input  logic [15:0] mem_rdata,
    output logic [15:0] cpu_stall_count
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        DMA_ACC
    } state_t;

    localparam int RUN_W = (MAX_CPU_RUN < 1) ? 1 : $clog2(MAX_CPU_RUN + 1);

    state_t           r_state;
    logic [3:0]       r_wait;
    logic [RUN_W-1:0] r_run;
    logic             r_is_wr;
    logic [14:0]      r_mem_addr;
    logic [15:0]      r_mem_wdata;
    logic             r_mem_wr;
    logic [1:0]       r_mem_wr_mask;

    logic w_done;
    logic w_capture;
    logic w_run_full;
    logic w_pick_dma;

    // Last cycle of an access: the wait counter has run down to zero.
    assign w_done     = (r_state != IDLE) && (r_wait == 4'd0);
    assign w_capture  = (r_state == IDLE) || w_done;
    assign w_pick_dma = dma_req && w_run_full;

    generate
        if (MAX_CPU_RUN == 0) begin : g_dma_first
            assign w_run_full = 1'b1;
        end else begin : g_dma_after_run
            assign w_run_full = (r_run >= RUN_W'(MAX_CPU_RUN));
        end
    endgenerate

    // NOTE: every register here is state, so all updates are non-blocking; blocking
    // assignments would let one branch see values written earlier in the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_wait        <= 4'd0;
            r_run         <= '0;
            r_is_wr       <= 1'b0;
            r_mem_addr    <= 15'd0;
            r_mem_wdata   <= 16'd0;
            r_mem_wr      <= 1'b0;
            r_mem_wr_mask <= 2'b00;
        end else if (w_capture) begin
            r_wait <= 4'(WAIT_STATES);
            if (w_pick_dma) begin
                r_state       <= DMA_ACC;
                r_mem_addr    <= dma_addr;
                r_mem_wdata   <= dma_wdata;
                r_is_wr       <= dma_wr;
                r_mem_wr      <= dma_wr;
                r_mem_wr_mask <= 2'b11;
                r_run         <= '0;
            end else begin
                r_state       <= CPU_ACC;
                r_mem_addr    <= memory_address;
                r_mem_wdata   <= memory_out;
                r_is_wr       <= memory_wr;
                // A write with no byte enabled still completes but never strobes the store.
                r_mem_wr      <= memory_wr && (memory_wr_mask != 2'b00);
                r_mem_wr_mask <= memory_wr ? memory_wr_mask : 2'b11;
                if (!w_run_full) begin
                    r_run <= r_run + RUN_W'(1);
                end
            end
        end else begin
            r_wait <= r_wait - 4'd1;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wr      = r_mem_wr;
    assign mem_wr_mask = r_mem_wr_mask;

    // NOTE: completion flags decode registered state; read data must pass straight
    // through because the store answers asynchronously within the completion cycle.
    assign memory_success = w_done && (r_state == CPU_ACC);
    assign dma_ack        = w_done && (r_state == DMA_ACC);
    assign memory_in      = (memory_success && !r_is_wr) ? mem_rdata : 16'd0;
    assign dma_rdata      = (dma_ack && !r_is_wr) ? mem_rdata : 16'd0;

`ifdef SLURM16_MEM_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_count <= 16'd0;
        end else if ((r_state == DMA_ACC) && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign cpu_stall_count = r_stall_count;
`else
    assign cpu_stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_slurm16_memory_responder.sv
// Directed bench for slurm16_memory_responder: four instances with different wait-state and
// starvation settings, each backed by a small SRAM model that commits a full-length write pulse.

module tb_slurm16_memory_responder;

    localparam int NDUT = 4;
    // instance:                          3      2      1      0
    localparam bit [3:0][7:0] WS_TAB  = {8'd1, 8'd3, 8'd2, 8'd0};
    localparam bit [3:0][7:0] MAX_TAB = {8'd0, 8'd0, 8'd4, 8'd4};

    logic        CLK = 1'b0;
    logic        RST            [NDUT];
    logic [14:0] memory_address [NDUT];
    logic [15:0] memory_out     [NDUT];
    logic        memory_wr      [NDUT];
    logic [1:0]  memory_wr_mask [NDUT];
    logic [15:0] memory_in      [NDUT];
    logic        memory_success [NDUT];
    logic [14:0] dma_addr       [NDUT];
    logic [15:0] dma_wdata      [NDUT];
    logic        dma_req        [NDUT];
    logic        dma_wr         [NDUT];
    logic [15:0] dma_rdata      [NDUT];
    logic        dma_ack        [NDUT];
    logic [14:0] mem_addr       [NDUT];
    logic [15:0] mem_wdata      [NDUT];
    logic        mem_wr         [NDUT];
    logic [1:0]  mem_wr_mask    [NDUT];
    logic [15:0] mem_rdata      [NDUT];
    logic [15:0] cpu_stall_count[NDUT];

    logic [15:0] store  [NDUT][4096];
    int          wr_run [NDUT];
    logic        init_done = 1'b0;

    int n_vectors     = 0;
    int n_miscompares = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        slurm16_memory_responder #(
            .WAIT_STATES(int'(WS_TAB[g])),
            .MAX_CPU_RUN(int'(MAX_TAB[g]))
        ) u_dut (
            .CLK            (CLK),
            .RST            (RST[g]),
            .memory_address (memory_address[g]),
            .memory_out     (memory_out[g]),
            .memory_wr      (memory_wr[g]),
            .memory_wr_mask (memory_wr_mask[g]),
            .memory_in      (memory_in[g]),
            .memory_success (memory_success[g]),
            .dma_addr       (dma_addr[g]),
            .dma_wdata      (dma_wdata[g]),
            .dma_req        (dma_req[g]),
            .dma_wr         (dma_wr[g]),
            .dma_rdata      (dma_rdata[g]),
            .dma_ack        (dma_ack[g]),
            .mem_addr       (mem_addr[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_wr         (mem_wr[g]),
            .mem_wr_mask    (mem_wr_mask[g]),
            .mem_rdata      (mem_rdata[g]),
            .cpu_stall_count(cpu_stall_count[g])
        );
        assign mem_rdata[g] = store[g][mem_addr[g][11:0]];
    end

    // SRAM model: a write lands only after the strobe has been held for 1+WAIT_STATES edges.
    always @(posedge CLK) begin
        if (!init_done) begin
            for (int k = 0; k < NDUT; k++) begin
                for (int a = 0; a < 4096; a++) store[k][a] <= 16'h0000;
                store[k][12'h010] <= 16'hA5A5;
                store[k][12'h011] <= 16'h5A5A;
                store[k][12'h100] <= 16'hABCD;
                store[k][12'h200] <= 16'hBEEF;
                wr_run[k] <= 0;
            end
            init_done <= 1'b1;
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                if (mem_wr[k]) begin
                    if (wr_run[k] == int'(WS_TAB[k])) begin
                        if (mem_wr_mask[k][1]) store[k][mem_addr[k][11:0]][15:8] <= mem_wdata[k][15:8];
                        if (mem_wr_mask[k][0]) store[k][mem_addr[k][11:0]][7:0]  <= mem_wdata[k][7:0];
                        wr_run[k] <= 0;
                    end else begin
                        wr_run[k] <= wr_run[k] + 1;
                    end
                end else begin
                    wr_run[k] <= 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_req(input int d, input logic [14:0] addr, input logic [15:0] data,
                           input logic wr, input logic [1:0] mask);
        memory_address[d] = addr;
        memory_out[d]     = data;
        memory_wr[d]      = wr;
        memory_wr_mask[d] = mask;
    endtask

    task automatic dma_set(input int d, input logic req, input logic [14:0] addr,
                           input logic [15:0] data, input logic wr);
        dma_req[d]   = req;
        dma_addr[d]  = addr;
        dma_wdata[d] = data;
        dma_wr[d]    = wr;
    endtask

    // Waits (bounded) for memory_success; cycles = -1 when the budget runs out.
    task automatic wait_cpu(input int d, input int budget, output int cycles,
                            output int wr_hi, output logic [15:0] rd);
        bit done = 1'b0;
        cycles = 0;
        wr_hi  = 0;
        rd     = 16'h0000;
        while (!done && cycles < budget) begin
            @(negedge CLK);
            cycles++;
            if (mem_wr[d]) wr_hi++;
            if (memory_success[d]) begin
                rd   = memory_in[d];
                done = 1'b1;
            end
        end
        if (!done) cycles = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          cyc, whi, cnt, acks;
        logic [15:0] rd;
        logic [1:0]  exp_sa;

        for (int k = 0; k < NDUT; k++) begin
            RST[k] = 1'b1;
            cpu_req(k, 15'h0010, 16'h0000, 1'b0, 2'b11);
            dma_set(k, 1'b0, 15'h0000, 16'h0000, 1'b0);
        end
        repeat (3) @(negedge CLK);

        // Reset state of every instance.
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_flags%0d", k), {memory_success[k], dma_ack[k], mem_wr[k]}, 3'b000);
            check($sformatf("rst_data%0d", k), {memory_in[k], dma_rdata[k]}, 32'h0);
            check($sformatf("rst_mem%0d", k), {mem_addr[k], mem_wr_mask[k], mem_wdata[k]}, 32'h0);
            check($sformatf("rst_stall%0d", k), cpu_stall_count[k], 32'h0);
        end

        // Instance 0 (WS=0): back-to-back reads, one cycle each.
        RST[0] = 1'b0;
        wait_cpu(0, 10, cyc, whi, rd);
        check("rd10_cycles", cyc, 1);
        check("rd10_data", rd, 16'hA5A5);
        cpu_req(0, 15'h0011, 16'h0000, 1'b0, 2'b11);
        wait_cpu(0, 10, cyc, whi, rd);
        check("rd11_cycles", cyc, 1);
        check("rd11_data", rd, 16'h5A5A);

        // Long CPU run: the run counter must saturate, not wrap, so DMA wins at once.
        for (int i = 0; i < 7; i++) begin
            wait_cpu(0, 10, cyc, whi, rd);
            check($sformatf("run%0d_cycles", i), cyc, 1);
        end
        dma_set(0, 1'b1, 15'h0200, 16'h0000, 1'b0);
        @(negedge CLK);
        check("sat_dma_first", {memory_success[0], dma_ack[0]}, 2'b01);
        check("sat_dma_rdata", dma_rdata[0], 16'hBEEF);
        dma_req[0] = 1'b0;
        @(negedge CLK);
        check("sat_cpu_back", {memory_success[0], dma_ack[0]}, 2'b10);

        // Instance 0 fresh from reset with dma_req held: 4 CPU, 1 DMA, repeating.
        RST[0] = 1'b1;
        cpu_req(0, 15'h0010, 16'h0000, 1'b0, 2'b11);
        dma_set(0, 1'b1, 15'h0200, 16'h0000, 1'b0);
        @(negedge CLK);
        RST[0] = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge CLK);
            exp_sa = (i % 5 == 0) ? 2'b01 : 2'b10;
            check($sformatf("pat_c%0d", i), {memory_success[0], dma_ack[0]}, exp_sa);
            if (i % 5 == 0) check($sformatf("pat_dma_rd%0d", i), dma_rdata[0], 16'hBEEF);
            else            check($sformatf("pat_cpu_rd%0d", i), memory_in[0], 16'hA5A5);
        end
        dma_req[0] = 1'b0;

        // Instance 1 (WS=2): high-byte write, readback, mask-00 write.
        cpu_req(1, 15'h0100, 16'h1234, 1'b1, 2'b10);
        RST[1] = 1'b0;
        wait_cpu(1, 20, cyc, whi, rd);
        check("wr_cycles", cyc, 3);
        check("wr_strobe_cycles", whi, 3);
        check("wr_memory_in", rd, 16'h0000);
        cpu_req(1, 15'h0100, 16'h0000, 1'b0, 2'b01);
        wait_cpu(1, 20, cyc, whi, rd);
        check("rdback_cycles", cyc, 3);
        check("rdback_data", rd, 16'h12CD);
        check("rd_mask_forced", mem_wr_mask[1], 2'b11);
        cpu_req(1, 15'h0100, 16'hFFFF, 1'b1, 2'b00);
        wait_cpu(1, 20, cyc, whi, rd);
        check("mask00_cycles", cyc, 3);
        check("mask00_strobe", whi, 0);
        check("mask00_store", store[1][12'h100], 16'h12CD);

        // A DMA request dropped before any capture edge is never served.
        cpu_req(1, 15'h0010, 16'h0000, 1'b0, 2'b11);
        @(negedge CLK);
        dma_set(1, 1'b1, 15'h0200, 16'h0000, 1'b0);
        @(negedge CLK);
        dma_req[1] = 1'b0;
        @(negedge CLK);
        check("cancel_cpu_done", memory_success[1], 1'b1);
        acks = 0;
        repeat (6) begin
            @(negedge CLK);
            if (dma_ack[1]) acks++;
        end
        check("cancel_no_ack", acks, 0);

        // Instance 2 (WS=3, MAX_CPU_RUN=0): DMA takes the first slot.
        dma_set(2, 1'b1, 15'h0200, 16'h0000, 1'b0);
        RST[2] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            exp_sa = (i == 4) ? 2'b01 : 2'b00;
            check($sformatf("dmafirst_c%0d", i), {memory_success[2], dma_ack[2]}, exp_sa);
        end
        check("dmafirst_rdata", dma_rdata[2], 16'hBEEF);
        dma_req[2] = 1'b0;
        wait_cpu(2, 20, cyc, whi, rd);
        check("dmafirst_cpu_cycles", cyc, 4);
        check("dmafirst_cpu_data", rd, 16'hA5A5);

        // Reset during cycle 2 of a write abandons it.
        cpu_req(2, 15'h0100, 16'h5555, 1'b1, 2'b11);
        @(negedge CLK);
        check("abort_wr_c1", mem_wr[2], 1'b1);
        @(negedge CLK);
        RST[2] = 1'b1;
        #1;
        check("abort_wr_drop", {mem_wr[2], memory_success[2]}, 2'b00);
        cnt = 0;
        repeat (5) begin
            @(negedge CLK);
            if (memory_success[2] || mem_wr[2]) cnt++;
        end
        check("abort_quiet", cnt, 0);
        check("abort_store", store[2][12'h100], 16'hABCD);

        // Instance 3 (WS=1, MAX_CPU_RUN=0): three DMA writes, then stall statistic.
        dma_set(3, 1'b1, 15'h0300, 16'h0F0F, 1'b1);
        RST[3] = 1'b0;
        acks = 0;
        cyc  = 0;
        while (acks < 3 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (dma_ack[3]) begin
                acks++;
                check($sformatf("dmawr_rdata%0d", acks), dma_rdata[3], 16'h0000);
            end
        end
        dma_req[3] = 1'b0;
        check("dmawr_acks", acks, 3);
        check("dmawr_cycles", cyc, 6);
        repeat (2) @(negedge CLK);
        check("dmawr_store", store[3][12'h300], 16'h0F0F);
`ifdef SLURM16_MEM_STATS_EN
        check("stall_count", cpu_stall_count[3], 16'd6);
`else
        check("stall_count", cpu_stall_count[3], 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/slurm16_memory_responder.md
Name: slurm16_memory_responder

Overview:
Target end of the CPU memory bus. Accepts word accesses from the CPU top (memory_address/out/wr/wr_mask) and answers with memory_in/memory_success. Arbitrates the single backing store between the CPU and one DMA master, using a starvation limit and configurable SRAM wait states. Sits between the CPU top and the on-chip/external SRAM.

Parameters:
WAIT_STATES, 0, extra cycles each backing-store access is held (0..15).
MAX_CPU_RUN, 4, consecutive CPU accesses allowed while DMA is pending before DMA gets a slot (0 = DMA always first).

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
memory_address  in  15  CPU word address
memory_out  in  16  CPU write data
memory_wr  in  1  CPU write (0 = read)
memory_wr_mask  in  2  byte enables: [1] high byte, [0] low byte
memory_in  out  16  read data to CPU
memory_success  out  1  CPU access complete this cycle
dma_addr  in  15  DMA word address
dma_wdata  in  16  DMA write data
dma_req  in  1  DMA request; held until dma_ack
dma_wr  in  1  DMA write (0 = read)
dma_rdata  out  16  read data to DMA
dma_ack  out  1  DMA access complete this cycle
mem_addr  out  15  backing-store address
mem_wdata  out  16  backing-store write data
mem_wr  out  1  backing-store write strobe
mem_wr_mask  out  2  backing-store byte enables
mem_rdata  in  16  backing-store read data, asynchronous
cpu_stall_count  out  16  stall statistic (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, run counter 0. Asserting RST mid-access abandons the access: no success/ack and no further mem_wr.
- CPU always presents a request. It holds address, data, wr and mask stable until it samples memory_success=1. It may present the next request in the success cycle.
- States:
  - IDLE
  - CPU_ACC
  - DMA_ACC
- Capture: on every edge where state is IDLE, or the current access completes, the arbiter picks the next owner and registers its request into mem_addr/mem_wdata/mem_wr/mem_wr_mask. The wait counter loads WAIT_STATES.
- Arbitration:
  - DMA wins if dma_req=1 and run_count >= MAX_CPU_RUN.
  - Otherwise the CPU wins.
  - run_count increments (saturating) per CPU capture and clears on each DMA capture.
  - With no dma_req, the CPU always wins.
- Access: lasts 1+WAIT_STATES cycles and the mem_* outputs are stable throughout. Completion happens in the last cycle (counter = 0). In that cycle:
  - CPU access: memory_success=1, memory_in=mem_rdata for reads, 0 for writes.
  - DMA access: dma_ack=1, dma_rdata=mem_rdata for reads, 0 for writes.
  - memory_in, dma_rdata, memory_success and dma_ack are 0 in all other cycles.
- Latency: a CPU request captured at edge N completes in cycle N+1+WAIT_STATES. With WAIT_STATES=0 and no DMA, back-to-back throughput is one access per cycle after the first.
- mem_wr is high for every cycle of a write access, but only if mask != 00. A write with mask 00 still completes with success and leaves memory unmodified. Reads force mem_wr_mask=11.
- DMA is captured only when dma_req=1. Dropping dma_req before capture cancels the request.
- When run_count overflows, it saturates at MAX_CPU_RUN.

Optional Feature:
SLURM16_MEM_STATS_EN: when defined, cpu_stall_count increments every cycle the state is DMA_ACC, saturates at 16'hFFFF, and clears only on reset. When undefined, cpu_stall_count is tied to 0 and no counter logic is generated.

Test Plan:
- WAIT_STATES=0, no DMA, CPU reads addresses 0x0010 and 0x0011 back-to-back (store holds 0xA5A5, 0x5A5A) -> memory_success in cycles 1 and 2 with memory_in 0xA5A5 then 0x5A5A.
- WAIT_STATES=2, CPU writes 0x1234 to 0x0100 with mask 10 -> mem_wr high for 3 cycles, success in cycle 3. Reading it back gives 0x12xx with the low byte unchanged.
- MAX_CPU_RUN=4, dma_req held with dma_addr 0x0200 -> exactly 4 CPU successes, then one dma_ack, then CPU resumes. The pattern repeats while dma_req stays high.
- MAX_CPU_RUN=0, dma_req high from reset -> the first capture goes to DMA, dma_ack is asserted, and memory_success stays 0 for that access.
- RST pulsed during cycle 2 of a WAIT_STATES=3 CPU write -> no memory_success, mem_wr drops to 0 immediately, and the target word is unchanged apart from reset-time effects.
- With SLURM16_MEM_STATS_EN defined and WAIT_STATES=1, three DMA accesses -> cpu_stall_count=6. Without the macro -> cpu_stall_count=0.
